sram_like_bridge: RTL and testbench

- Next-generation memory front end for the mips core.
- Replaces the fixed single-cycle inst/data SRAM hookup with N_CH core-side request channels, arbitrated onto one shared SRAM-like master bus (req/addr_ok/data_ok handshake).
- One outstanding bus transaction at a time.
- Generates per-channel completion pulses, which the core uses to release pipeline stalls.

---
 rtl/sram_like_bridge_pkg.sv | 20 ++
 rtl/sram_like_bridge_if.sv | 24 ++
 rtl/sram_like_bridge_arbiter.sv | 43 ++++
 rtl/sram_like_bridge.sv | 108 ++++++++++
 tb/tb_sram_like_bridge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the SRAM-like bridge: FSM state encoding and bus size codes.
package sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Code 3 is reserved on the core side; the bus only ever sees byte/half/word.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// SRAM-like master bus: req/addr_ok request phase, data_ok response phase.
interface sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_like_bridge_arbiter.sv
// Combinational channel arbiter. Fixed priority (highest index wins) by default;
// round-robin starting after last_grant when SRAM_LIKE_BRIDGE_RR_ARB_EN is defined.
module sram_like_bridge_arbiter #(
  parameter int N_CH  = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_CH-1:0]  req,
`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
  input  logic [IDX_W-1:0] last_grant,
`endif
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_CH);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/sram_like_bridge.sv
// Multi-channel core front end onto one SRAM-like bus, one transaction in flight.
// Optional round-robin arbitration: SRAM_LIKE_BRIDGE_RR_ARB_EN.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CH-1:0]        cpu_req,
  input  logic [N_CH-1:0]        cpu_wr,
  input  logic [2*N_CH-1:0]      cpu_size,
  input  logic [ADDR_W*N_CH-1:0] cpu_addr,
  input  logic [DATA_W*N_CH-1:0] cpu_wdata,
  output logic [DATA_W*N_CH-1:0] cpu_rdata,
  output logic [N_CH-1:0]        cpu_done,
  sram_like_bridge_if.master     bus
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t                        state;
  logic [IDX_W-1:0]              grant;
  logic [IDX_W-1:0]              arb_idx;
  logic                          arb_any;
  logic [N_CH-1:0][1:0]          size_v;
  logic [N_CH-1:0][ADDR_W-1:0]   addr_v;
  logic [N_CH-1:0][DATA_W-1:0]   wdata_v;
  logic [N_CH-1:0][DATA_W-1:0]   rdata_q;

  assign size_v    = cpu_size;
  assign addr_v    = cpu_addr;
  assign wdata_v   = cpu_wdata;
  assign cpu_rdata = rdata_q;

`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
  logic [IDX_W-1:0] last_grant;
`endif

  sram_like_bridge_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (cpu_req),
`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
    .last_grant (last_grant),
`endif
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      grant         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_wr    <= 1'b0;
      bus.bus_size  <= 2'd0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      cpu_done      <= '0;
      rdata_q       <= '0;
`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
      last_grant    <= '0;
`endif
    end else begin
      case (state)
        // Snapshot the winner's request; later changes on cpu_* are ignored.
        IDLE: begin
          if (arb_any) begin
            grant         <= arb_idx;
            bus.bus_req   <= 1'b1;
            bus.bus_wr    <= cpu_wr[arb_idx];
            bus.bus_size  <= norm_size(size_v[arb_idx]);
            bus.bus_addr  <= addr_v[arb_idx];
            bus.bus_wdata <= wdata_v[arb_idx];
            state         <= REQ;
          end
        end
        // data_ok cannot legally arrive before addr_ok, so it is not looked at here.
        REQ: begin
          if (bus.bus_addr_ok) begin
            bus.bus_req <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.bus_data_ok) begin
            if (!bus.bus_wr) rdata_q[grant] <= bus.bus_rdata;
            cpu_done[grant] <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          cpu_done   <= '0;
`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
          last_grant <= grant;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed steps plus randomized traffic
// against a transaction-level model of arbitration, bus fields and read data.
module tb_sram_like_bridge;

  localparam int N_CH = 2;
`ifdef SRAM_LIKE_BRIDGE_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  cpu_req, cpu_wr, cpu_done;
  logic [3:0]  cpu_size;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;

  always #5 clk = ~clk;

  sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_like_bridge #(.N_CH(N_CH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_size  (cpu_size),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .bus       (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata [N_CH];
  int          last_gnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: highest index, or first requester after the last grant.
  function automatic int pick(input logic [1:0] req);
    int c;
    if (RR) begin
      for (int k = 1; k <= N_CH; k++) begin
        c = (last_gnt + k) % N_CH;
        if (req[c]) return c;
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) if (req[i]) return i;
    end
    return 0;
  endfunction

  task automatic set_ch(input int ch, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    cpu_req[ch]          = 1'b1;
    cpu_wr[ch]           = wr;
    cpu_size[ch*2 +: 2]  = sz;
    cpu_addr[ch*32 +: 32]  = a;
    cpu_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic chk_rdata(input string tag);
    chk({tag, "_rdata0"}, cpu_rdata[31:0],  exp_rdata[0]);
    chk({tag, "_rdata1"}, cpu_rdata[63:32], exp_rdata[1]);
  endtask

  // Called at a negedge in IDLE with requests already applied; returns at the
  // negedge of the IDLE cycle following DONE.
  task automatic do_txn(input string tag, input int adly, input int ddly,
                        input logic [31:0] rdv, input bit keep, input bit spur,
                        output int served);
    int          ch;
    logic [31:0] ea, ew;
    logic [1:0]  es;
    logic        ewr;
    ch  = pick(cpu_req);
    ea  = cpu_addr[ch*32 +: 32];
    ew  = cpu_wdata[ch*32 +: 32];
    es  = cpu_size[ch*2 +: 2];
    ewr = cpu_wr[ch];
    if (es == 2'd3) es = 2'd2;
    served = ch;
    @(negedge clk);
    // A waiting loser may change its fields; only the IDLE snapshot matters.
    cpu_addr[(1-ch)*32 +: 32]  = $urandom;
    cpu_wdata[(1-ch)*32 +: 32] = $urandom;
    for (int i = 0; i <= adly; i++) begin
      chk({tag, "_bus_req"},   bus.bus_req,   1);
      chk({tag, "_bus_addr"},  bus.bus_addr,  ea);
      chk({tag, "_bus_wr"},    bus.bus_wr,    ewr);
      chk({tag, "_bus_size"},  bus.bus_size,  es);
      chk({tag, "_bus_wdata"}, bus.bus_wdata, ew);
      chk({tag, "_done_req"},  cpu_done,      0);
      bus.bus_addr_ok = (i == adly);
      bus.bus_data_ok = spur && (i != adly);
      @(negedge clk);
    end
    bus.bus_addr_ok = 1'b0;
    bus.bus_data_ok = 1'b0;
    for (int j = 0; j <= ddly; j++) begin
      chk({tag, "_resp_req"},  bus.bus_req, 0);
      chk({tag, "_done_resp"}, cpu_done,    0);
      bus.bus_data_ok = (j == ddly);
      bus.bus_rdata   = (j == ddly) ? rdv : $urandom;
      @(negedge clk);
    end
    bus.bus_data_ok = 1'b0;
    bus.bus_rdata   = $urandom;
    if (!ewr) exp_rdata[ch] = rdv;
    chk({tag, "_done"},      cpu_done,    64'(2'b01 << ch));
    chk({tag, "_done_breq"}, bus.bus_req, 0);
    chk_rdata(tag);
    if (RR) last_gnt = ch;
    if (!keep) cpu_req[ch] = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_done"}, cpu_done,    0);
    chk({tag, "_idle_req"},  bus.bus_req, 0);
  endtask

  initial begin
    int served;
    resetn          = 1'b0;
    cpu_req         = '0;
    cpu_wr          = '0;
    cpu_size        = '0;
    cpu_addr        = '0;
    cpu_wdata       = '0;
    bus.bus_addr_ok = 1'b0;
    bus.bus_data_ok = 1'b0;
    bus.bus_rdata   = '0;
    for (int c = 0; c < N_CH; c++) exp_rdata[c] = '0;
    repeat (3) @(negedge clk);

    chk("rst_bus_req",   bus.bus_req,   0);
    chk("rst_bus_wr",    bus.bus_wr,    0);
    chk("rst_bus_size",  bus.bus_size,  0);
    chk("rst_bus_addr",  bus.bus_addr,  0);
    chk("rst_bus_wdata", bus.bus_wdata, 0);
    chk("rst_done",      cpu_done,      0);
    chk("rst_rdata",     cpu_rdata,     0);
    resetn = 1'b1;
    @(negedge clk);

    // Single read on ch0, minimum latency.
    set_ch(0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    do_txn("rd0", 0, 0, 32'h3C1D_8000, 1'b0, 1'b0, served);
    chk("rd0_ch", served, 0);
    chk("rd0_rdata", cpu_rdata[31:0], 32'h3C1D_8000);

    // Simultaneous ch0 read and ch1 write: ch1 goes first.
    set_ch(0, 1'b0, 2'd2, 32'h0000_1000, 32'h0);
    set_ch(1, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF);
    do_txn("arb_a", 0, 0, 32'h1111_2222, 1'b0, 1'b0, served);
    chk("arb_first", served, 1);
    chk("arb_wr_rdata1", cpu_rdata[63:32], 32'h0);
    do_txn("arb_b", 0, 1, 32'h5A5A_0F0F, 1'b0, 1'b0, served);
    chk("arb_second", served, 0);

    // Long addr_ok / data_ok stalls.
    set_ch(0, 1'b0, 2'd1, 32'h0000_2002, 32'h0);
    do_txn("stall", 5, 4, 32'hCAFE_F00D, 1'b0, 1'b0, served);

    // Spurious data_ok during the request phase.
    set_ch(1, 1'b0, 2'd3, 32'h0000_3000, 32'h0);
    do_txn("spur", 3, 1, 32'h7777_8888, 1'b0, 1'b1, served);
    chk("spur_rdata1", cpu_rdata[63:32], 32'h7777_8888);

    // Reset while waiting for data_ok, then the held request is re-issued.
    set_ch(0, 1'b0, 2'd0, 32'h0000_0041, 32'h0);
    @(negedge clk);
    chk("rr_req_phase", bus.bus_req, 1);
    bus.bus_addr_ok = 1'b1;
    @(negedge clk);
    bus.bus_addr_ok = 1'b0;
    chk("rr_resp_phase", bus.bus_req, 0);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_bus_req",  bus.bus_req,   0);
    chk("mid_rst_bus_addr", bus.bus_addr,  0);
    chk("mid_rst_bus_size", bus.bus_size,  0);
    chk("mid_rst_done",     cpu_done,      0);
    chk("mid_rst_rdata",    cpu_rdata,     0);
    for (int c = 0; c < N_CH; c++) exp_rdata[c] = '0;
    last_gnt = 0;
    resetn = 1'b1;
    do_txn("reissue", 1, 1, 32'h0BAD_F00D, 1'b0, 1'b0, served);
    chk("reissue_ch", served, 0);

    // Both channels requesting continuously.
    set_ch(0, 1'b0, 2'd2, 32'h0000_4000, 32'h0);
    set_ch(1, 1'b0, 2'd2, 32'h0000_5000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      do_txn("cont", 0, 0, $urandom, 1'b1, 1'b0, served);
      chk("cont_grant", served, RR ? ((k % 2 == 0) ? 1 : 0) : 1);
    end
    cpu_req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("quiet_bus_req", bus.bus_req, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        cpu_wr[c]              = 1'($urandom_range(0, 1));
        cpu_size[c*2 +: 2]     = 2'($urandom_range(0, 3));
        cpu_addr[c*32 +: 32]   = $urandom;
        cpu_wdata[c*32 +: 32]  = $urandom;
        if (!cpu_req[c]) cpu_req[c] = 1'($urandom_range(0, 1));
      end
      if (cpu_req == '0) cpu_req[$urandom_range(0, 1)] = 1'b1;
      do_txn("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             1'b0, 1'($urandom_range(0, 1)), served);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
